// File: rtl/mmio_seq.sv
// Note sequencer MMIO slot: plays a 16-entry note table into the DDFS (freq)
// and ADSR (gate) at tick-accurate durations once firmware issues start.
module mmio_seq #(
    parameter int N_STEPS = 16,
    parameter int FREQ_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cs,
    input  logic              i_write,
    input  logic              i_read,
    input  logic [4:0]        i_addr,
    input  logic [31:0]       i_write_data,
    output logic [31:0]       o_read_data,
    output logic [FREQ_W-1:0] o_freq,
    output logic              o_gate,
    output logic              o_step_strobe,
    output logic              o_busy
);
    typedef enum logic [1:0] {IDLE, LOAD, ON, OFF} state_t;

    state_t      state, state_nxt;
    logic [31:0] tbl [N_STEPS];
    logic [31:0] tick_div;
    logic [4:0]  length_r;
    logic        loop_r;
    logic [3:0]  index;
    logic [31:0] tick_cnt;
    logic [7:0]  ticks_left;
    logic [7:0]  cur_off;

    logic        wr, ctrl_wr, cmd_start, cmd_stop;
    logic [4:0]  len_eff;
    logic [31:0] div_eff, ld;
    logic [7:0]  ld_on, ld_off;
    logic        tick_end, last_tick, step_last, eos, enter_timed;
    logic        unused_rd;

    assign unused_rd = i_read;

    assign wr        = i_cs & i_write;
    assign ctrl_wr   = wr && (i_addr == 5'd0);
    assign len_eff   = (length_r > 5'd16) ? 5'd16 : length_r;
    assign cmd_stop  = ctrl_wr & i_write_data[1];
    assign cmd_start = ctrl_wr & i_write_data[0] & ~i_write_data[1] & (len_eff != 5'd0);
    assign div_eff   = (tick_div == 32'd0) ? 32'd1 : tick_div;
    assign ld        = tbl[index];
    assign ld_on     = ld[23:16];
    assign ld_off    = ld[31:24];
    assign tick_end  = tick_cnt >= (div_eff - 32'd1);
    assign last_tick = tick_end && (ticks_left <= 8'd1);
    // >= rather than == so a LENGTH shrunk mid-play still terminates the pass
    assign step_last = ({1'b0, index} + 5'd1) >= len_eff;
    assign enter_timed = ((state_nxt == ON) || (state_nxt == OFF)) && (state_nxt != state);

    always_ff @(posedge i_clk) begin
        if (i_reset) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        eos       = 1'b0;
        case (state)
            LOAD: begin
                if (ld_on != 8'd0)       state_nxt = ON;
                else if (ld_off != 8'd0) state_nxt = OFF;
                else                     eos = 1'b1;
            end
            ON: if (last_tick) begin
                if (cur_off != 8'd0) state_nxt = OFF;
                else                 eos = 1'b1;
            end
            OFF: if (last_tick) eos = 1'b1;
            default: ;
        endcase
        if (eos)       state_nxt = (step_last && !loop_r) ? IDLE : LOAD;
        if (cmd_start) state_nxt = LOAD;
        if (cmd_stop)  state_nxt = IDLE;
    end

    always_comb begin
        o_gate = (state == ON);
        o_busy = (state != IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k < N_STEPS; k++) tbl[k] <= '0;
            tick_div      <= '0;
            length_r      <= '0;
            loop_r        <= 1'b0;
            index         <= '0;
            tick_cnt      <= '0;
            ticks_left    <= '0;
            cur_off       <= '0;
            o_freq        <= '0;
            o_step_strobe <= 1'b0;
        end else begin
            if (wr) begin
                if (i_addr[4]) tbl[i_addr[3:0]] <= i_write_data;
                else case (i_addr[3:0])
                    4'd2:    tick_div <= i_write_data;
                    4'd3:    length_r <= i_write_data[4:0];
                    default: ;
                endcase
            end
            if (ctrl_wr) loop_r <= i_write_data[2];

            if (enter_timed || !(state == ON || state == OFF)) tick_cnt <= '0;
            else tick_cnt <= tick_end ? 32'd0 : tick_cnt + 32'd1;

            if (state == LOAD) begin
                ticks_left <= (ld_on != 8'd0) ? ld_on : ld_off;
                cur_off    <= ld_off;
            end else if (state == ON && tick_end) begin
                ticks_left <= (ticks_left <= 8'd1) ? cur_off : ticks_left - 8'd1;
            end else if (state == OFF && tick_end) begin
                ticks_left <= ticks_left - 8'd1;
            end

            if (cmd_stop || cmd_start) index <= '0;
            else if (eos)              index <= step_last ? 4'd0 : index + 4'd1;

            // freq only moves on a sounding step; rests leave the DDFS untouched
            o_step_strobe <= (state == LOAD) && (state_nxt == ON);
            if ((state == LOAD) && (state_nxt == ON)) o_freq <= ld[FREQ_W-1:0];
        end
    end

    always_comb begin
        o_read_data = '0;
        if (i_addr[4]) o_read_data = tbl[i_addr[3:0]];
        else case (i_addr[3:0])
            4'd1:    o_read_data = {23'd0, loop_r, index, 3'd0, o_busy};
            4'd2:    o_read_data = tick_div;
            4'd3:    o_read_data = {27'd0, length_r};
            default: ;
        endcase
    end
endmodule
